puf_race_reader: RTL and testbench

- Drives and reads back the arbiter-PUF delay line. Each accepted challenge fires C_REPEAT launch pulses into the line, and each launch is judged by a clocked race arbiter.
- A majority vote over the launches gives one response bit. The bit and its vote count are returned on a valid/ready handshake.
- Sits between the challenge source (host/UART controller) and the delay-line instance.

---
 rtl/puf_race_reader.sv | 160 ++++++++++++++++
 tb/tb_puf_race_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_race_reader.sv
// puf_race_reader: launches C_REPEAT pulses into an arbiter-PUF delay line for
// each accepted challenge, judges each race with a clocked arbiter and returns a
// majority-vote response bit with its vote count over a valid/ready handshake.
// Optional build macro PUF_TIE_COUNT_EN adds otie_count (same-cycle ties).
module puf_race_reader #(
  parameter int C_LENGTH  = 3,
  parameter int C_REPEAT  = 7,
  parameter int C_TIMEOUT = 15,
  parameter int C_RELAX   = 2
) (
  input  logic                            iclk,
  input  logic                            irst_n,
  input  logic                            ichallenge_valid,
  input  logic [2*C_LENGTH-1:0]           ichallenge,
  output logic                            ochallenge_ready,
  output logic [2*C_LENGTH-1:0]           ochallenge_line,
  output logic                            opulse,
  input  logic                            irace_1,
  input  logic                            irace_2,
  output logic                            oresp_valid,
  output logic                            oresp,
  output logic [$clog2(C_REPEAT+1)-1:0]   ovotes,
  output logic                            otimeout,
  input  logic                            iresp_ready
`ifdef PUF_TIE_COUNT_EN
  ,
  output logic [$clog2(C_REPEAT+1)-1:0]   otie_count
`endif
);

  localparam int VW = $clog2(C_REPEAT + 1);
  localparam int TW = $clog2(C_TIMEOUT + 1);
  localparam int RW = $clog2(C_RELAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RACE,
    S_RELAX,
    S_RESP
  } state_t;

  state_t                state_q;
  logic                  ready_q;
  logic [2*C_LENGTH-1:0] line_q;
  logic                  pulse_q;
  logic                  resp_valid_q;
  logic                  resp_q;
  logic                  timeout_q;
  logic [VW-1:0]         votes_q;
  logic [VW-1:0]         launches_q;
  logic [TW-1:0]         race_cnt_q;
  logic [RW-1:0]         relax_cnt_q;
`ifdef PUF_TIE_COUNT_EN
  logic [VW-1:0]         tie_q;
`endif

  logic race_any;
  assign race_any = irace_1 | irace_2;

  // Challenge/launch/race/relax/response sequencer with all outputs registered.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      line_q       <= '0;
      pulse_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      timeout_q    <= 1'b0;
      votes_q      <= '0;
      launches_q   <= '0;
      race_cnt_q   <= '0;
      relax_cnt_q  <= '0;
`ifdef PUF_TIE_COUNT_EN
      tie_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ichallenge_valid && ready_q) begin
            ready_q    <= 1'b0;
            line_q     <= ichallenge;
            votes_q    <= '0;
            launches_q <= '0;
            timeout_q  <= 1'b0;
`ifdef PUF_TIE_COUNT_EN
            tie_q      <= '0;
`endif
            pulse_q    <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          race_cnt_q <= '0;
          state_q    <= S_RACE;
        end
        S_RACE: begin
          if (race_any) begin
            // A same-cycle tie is scored as a win for line 2.
            if (irace_1 && !irace_2) votes_q <= votes_q + VW'(1);
`ifdef PUF_TIE_COUNT_EN
            if (irace_1 && irace_2) tie_q <= tie_q + VW'(1);
`endif
            pulse_q     <= 1'b0;
            relax_cnt_q <= '0;
            state_q     <= S_RELAX;
          end else if (race_cnt_q == TW'(C_TIMEOUT - 1)) begin
            timeout_q   <= 1'b1;
            pulse_q     <= 1'b0;
            relax_cnt_q <= '0;
            state_q     <= S_RELAX;
          end else begin
            race_cnt_q <= race_cnt_q + TW'(1);
          end
        end
        S_RELAX: begin
          if (race_any) begin
            relax_cnt_q <= '0;
          end else if (relax_cnt_q == RW'(C_RELAX - 1)) begin
            relax_cnt_q <= '0;
            launches_q  <= launches_q + VW'(1);
            if (launches_q == VW'(C_REPEAT - 1)) begin
              resp_valid_q <= 1'b1;
              resp_q       <= (votes_q > VW'(C_REPEAT / 2));
              state_q      <= S_RESP;
            end else begin
              pulse_q <= 1'b1;
              state_q <= S_LAUNCH;
            end
          end else begin
            relax_cnt_q <= relax_cnt_q + RW'(1);
          end
        end
        S_RESP: begin
          if (iresp_ready) begin
            resp_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ochallenge_ready = ready_q;
  assign ochallenge_line  = line_q;
  assign opulse           = pulse_q;
  assign oresp_valid      = resp_valid_q;
  assign oresp            = resp_q;
  assign ovotes           = votes_q;
  assign otimeout         = timeout_q;
`ifdef PUF_TIE_COUNT_EN
  assign otie_count       = tie_q;
`endif

endmodule

// File: tb/tb_puf_race_reader.sv
// Directed bench for puf_race_reader with a behavioural delay-line model.
module tb_puf_race_reader;

  logic       iclk = 1'b0;
  logic       irst_n = 1'b0;
  logic       ichallenge_valid = 1'b0;
  logic [5:0] ichallenge = '0;
  logic       ochallenge_ready;
  logic [5:0] ochallenge_line;
  logic       opulse;
  logic       irace_1 = 1'b0;
  logic       irace_2 = 1'b0;
  logic       oresp_valid;
  logic       oresp;
  logic [2:0] ovotes;
  logic       otimeout;
  logic       iresp_ready = 1'b0;
`ifdef PUF_TIE_COUNT_EN
  logic [2:0] otie_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;

  puf_race_reader #(
    .C_LENGTH (3),
    .C_REPEAT (7),
    .C_TIMEOUT(15),
    .C_RELAX  (2)
  ) dut (
    .iclk            (iclk),
    .irst_n          (irst_n),
    .ichallenge_valid(ichallenge_valid),
    .ichallenge      (ichallenge),
    .ochallenge_ready(ochallenge_ready),
    .ochallenge_line (ochallenge_line),
    .opulse          (opulse),
    .irace_1         (irace_1),
    .irace_2         (irace_2),
    .oresp_valid     (oresp_valid),
    .oresp           (oresp),
    .ovotes          (ovotes),
    .otimeout        (otimeout),
    .iresp_ready     (iresp_ready)
`ifdef PUF_TIE_COUNT_EN
    ,
    .otie_count      (otie_count)
`endif
  );

  always #5 iclk = ~iclk;

  // Delay-line model: output x rises once opulse has been high for more than
  // its delay in cycles, and falls as soon as opulse drops.
  // mode 0 line1 fast, 1 line2 fast, 2 line1 wins odd launches, 3 even,
  // 4 no output ever, 5 tie on every launch.
  int hi_cnt = 0;
  int li = 0;
  always @(negedge iclk) begin
    int d1, d2;
    if (ochallenge_ready) li = 0;
    if (opulse) begin
      if (hi_cnt == 0) li = li + 1;
      hi_cnt = hi_cnt + 1;
    end else begin
      hi_cnt = 0;
    end
    case (mode)
      0: begin d1 = 1;  d2 = 3;  end
      1: begin d1 = 3;  d2 = 1;  end
      2: begin d1 = (li % 2 == 1) ? 1 : 3; d2 = (li % 2 == 1) ? 3 : 1; end
      3: begin d1 = (li % 2 == 0) ? 1 : 3; d2 = (li % 2 == 0) ? 3 : 1; end
      4: begin d1 = 99; d2 = 99; end
      default: begin d1 = 1; d2 = 1; end
    endcase
    irace_1 = opulse && (hi_cnt > d1);
    irace_2 = opulse && (hi_cnt > d2);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_challenge(input logic [5:0] v);
    int k = 0;
    @(negedge iclk);
    while (!ochallenge_ready && k < 100) begin
      @(negedge iclk);
      k++;
    end
    check_eq("accept_ready", int'(ochallenge_ready), 1);
    ichallenge       = v;
    ichallenge_valid = 1'b1;
    @(posedge iclk);
    #1 ichallenge_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 400) begin
      @(posedge iclk);
      lat++;
      #1;
      if (oresp_valid) break;
    end
    if (!oresp_valid) check_eq("resp_wait_expired", 0, 1);
  endtask

  task automatic consume();
    @(negedge iclk);
    iresp_ready = 1'b1;
    @(posedge iclk);
    #1 iresp_ready = 1'b0;
    check_eq("valid_drop", int'(oresp_valid), 0);
    check_eq("ready_back", int'(ochallenge_ready), 1);
  endtask

  task automatic run(input int m, input logic [5:0] ch, input int exp_resp,
                     input int exp_votes, input int exp_to);
    int lat;
    mode = m;
    send_challenge(ch);
    wait_resp(lat);
    check_eq("resp", int'(oresp), exp_resp);
    check_eq("votes", int'(ovotes), exp_votes);
    check_eq("timeout", int'(otimeout), exp_to);
    check_eq("line", int'(ochallenge_line), int'(ch));
    consume();
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    check_eq("rst_pulse", int'(opulse), 0);
    check_eq("rst_valid", int'(oresp_valid), 0);
    check_eq("rst_ready", int'(ochallenge_ready), 0);
    check_eq("rst_votes", int'(ovotes), 0);
    check_eq("rst_timeout", int'(otimeout), 0);
    check_eq("rst_line", int'(ochallenge_line), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1 check_eq("post_rst_ready", int'(ochallenge_ready), 1);

    // Line 1 fast: minimum latency, then backpressure
    mode = 0;
    send_challenge(6'h2A);
    check_eq("ready_busy", int'(ochallenge_ready), 0);
    wait_resp(lat);
    check_eq("latency", lat, 28);
    check_eq("l1_resp", int'(oresp), 1);
    check_eq("l1_votes", int'(ovotes), 7);
    check_eq("l1_timeout", int'(otimeout), 0);
    check_eq("l1_line", int'(ochallenge_line), 8'h2A);
    for (int i = 0; i < 10; i++) begin
      @(posedge iclk);
      #1;
      check_eq("bp_valid", int'(oresp_valid), 1);
      check_eq("bp_resp", int'(oresp), 1);
      check_eq("bp_votes", int'(ovotes), 7);
      check_eq("bp_ready", int'(ochallenge_ready), 0);
    end
    consume();

    run(1, 6'h15, 0, 0, 0);
    run(2, 6'h33, 1, 4, 0);
    run(3, 6'h0C, 0, 3, 0);
    run(4, 6'h3F, 0, 0, 1);

    // Timeout flag clears on the next accept
    mode = 0;
    send_challenge(6'h01);
    check_eq("to_cleared", int'(otimeout), 0);
    wait_resp(lat);
    check_eq("after_to_votes", int'(ovotes), 7);
    consume();

    // Ties scored as line 2
    mode = 5;
    send_challenge(6'h22);
    wait_resp(lat);
    check_eq("tie_resp", int'(oresp), 0);
    check_eq("tie_votes", int'(ovotes), 0);
`ifdef PUF_TIE_COUNT_EN
    check_eq("tie_count", int'(otie_count), 7);
`endif
    consume();

    // Asynchronous reset during RACE
    mode = 4;
    send_challenge(6'h2D);
    @(posedge iclk);
    #1 check_eq("in_race_pulse", int'(opulse), 1);
    irst_n = 1'b0;
    #1;
    check_eq("arst_pulse", int'(opulse), 0);
    check_eq("arst_valid", int'(oresp_valid), 0);
    check_eq("arst_line", int'(ochallenge_line), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1 check_eq("arst_ready", int'(ochallenge_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
